gnn_result_unloader: RTL and testbench
======================================

GNN_RESULT_UNLOADER -- requirements
Module: gnn_result_unloader

Interface
REQ-001 The block SHALL have parameter OUT_W, default 21, giving the signed width of each result word.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 out0_node0..out0_node3, out1_node0..out1_node3  input  OUT_W each  signed class scores, one pair per graph node.
REQ-005 out10_ready_node0..3, out11_ready_node0..3  input  1 each  per-score valid flags from the accelerator.
REQ-006 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-007 res_data  output  OUT_W  signed score word being offered.
REQ-008 res_tag  output  3  word index: bits[2:1] = node, bit[0] = score (0 = out0, 1 = out1).
REQ-009 res_argmax  output  1  decision for the node of the current word.
REQ-010 res_valid  output  1  the offered word is valid.
REQ-011 res_ready  input  1  downstream accepts the word.
REQ-012 res_last  output  1  the offered word is the final word of its frame.
REQ-013 err_partial, err_overflow  output  1 each  sticky error flags.
REQ-014 frame_cnt  output  8  count of completed frames.

Function
REQ-015 A capture event SHALL occur in any cycle in which all 8 ready inputs are 1.
REQ-016 A partial event SHALL occur in any cycle in which 1 to 7 ready inputs are 1.
- On a partial event the block SHALL capture nothing and SHALL set err_partial.
REQ-017 The FSM SHALL have exactly two states, IDLE and SEND, and SHALL reset to IDLE.
REQ-018 In IDLE, a capture event SHALL have the following effect on the next edge:
- load all 8 scores into an internal buffer;
- compute the argmax of each node;
- set idx to 0 and enter SEND.
REQ-019 The argmax of each node SHALL be 1 if out1 > out0 in a signed compare; otherwise, including ties, it SHALL be 0.
REQ-020 In SEND, res_valid SHALL be 1 and the outputs SHALL be driven as follows:
- res_data = buffer[idx];
- res_tag = idx;
- res_argmax = argmax of node idx[2:1];
- res_last = (idx == 7).
REQ-021 Word order SHALL be: node0 out0, node0 out1, node1 out0, node1 out1, and so on up to node3 out1.
REQ-022 A transfer SHALL occur when res_valid and res_ready are both 1.
- On a transfer with idx < 7, idx SHALL increment.
- On the transfer with idx == 7, the FSM SHALL return to IDLE and frame_cnt SHALL increment, wrapping 255 -> 0.
REQ-023 While res_valid=1 and res_ready=0, res_data, res_tag, res_argmax and res_last SHALL hold stable; res_valid SHALL NOT drop before the transfer completes.
REQ-024 In IDLE, res_valid and res_last SHALL be 0, and res_data, res_tag and res_argmax SHALL be 0.
REQ-025 A capture event arriving while in SEND, including the cycle of the final transfer, SHALL be dropped.
- A dropped capture SHALL set err_overflow.
- The buffer SHALL NOT change.
REQ-026 The minimum frame period SHALL be 9 cycles: 1 capture cycle plus 8 transfer cycles. The accelerator SHALL space frames at least 9 cycles apart.
REQ-027 clr_err=1 SHALL clear both error flags on the next edge.
- If an error event occurs in the same cycle as clr_err=1, the flag SHALL be set, i.e. set wins.
REQ-028 Latency SHALL be as follows:
- the first word is valid 1 cycle after the capture edge;
- res_data SHALL be registered, with no combinational path from the score inputs to res_data.

Reset
REQ-029 While rst_n=0 the block SHALL force the following, with no clock edge required:
- FSM = IDLE, idx = 0;
- all outputs = 0, including frame_cnt and both error flags.
REQ-030 Assertion of rst_n mid-frame SHALL abandon the frame. After release, the block SHALL wait in IDLE for a new capture event.
REQ-031 Capture SHALL NOT occur in the first edge after rst_n rises unless a capture event is present in that cycle.

Verification
REQ-032 Basic frame. Stimulus: all readies 1 for one cycle with scores n0 = (5, -3), n1 = (-2, 7), n2 = (4, 4), n3 = (-1048576, 1048575); res_ready held 1.
- Expected: 8 consecutive words 5, -3, -2, 7, 4, 4, -1048576, 1048575.
- Expected tags 0..7 and argmax 0,0,1,1,0,0,1,1.
- Expected res_last only on the 8th word, then frame_cnt = 1.
REQ-033 Backpressure. Stimulus: the REQ-032 frame with res_ready = 0 for 3 cycles at idx 2.
- Expected: res_data = -2 and res_tag = 2 held for 4 cycles, with no word lost or duplicated.
REQ-034 Overflow. Stimulus: a second all-ready capture at idx 4, then another in the final-transfer cycle.
- Expected: the first frame completes unchanged, err_overflow = 1, frame_cnt increments by only 1.
- Then clr_err -> err_overflow = 0.
REQ-035 Partial. Stimulus: only out10_ready_node2 = 1 for one cycle.
- Expected: err_partial = 1, res_valid remains 0.
- Then clr_err pulsed in the same cycle as another partial event -> err_partial remains 1.
REQ-036 Reset mid-frame. Stimulus: rst_n = 0 asynchronously at idx 5.
- Expected: res_valid = 0 immediately, frame_cnt = 0.
- After release, a new capture streams from idx 0.
REQ-037 Wrap. Stimulus: 256 complete frames.
- Expected: frame_cnt = 0; frame 257 -> frame_cnt = 1.

Source files
------------

// File: rtl/gnn_result_unloader.sv
// rtl/gnn_result_unloader.sv - captures one frame of per-node class scores and streams it out word by word
// Eight words per frame (node0 out0 .. node3 out1), each tagged with its index and the node's argmax.
module gnn_result_unloader #(
   parameter int OUT_W = 21
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [OUT_W-1:0] out0_node0,
   input  logic signed [OUT_W-1:0] out0_node1,
   input  logic signed [OUT_W-1:0] out0_node2,
   input  logic signed [OUT_W-1:0] out0_node3,
   input  logic signed [OUT_W-1:0] out1_node0,
   input  logic signed [OUT_W-1:0] out1_node1,
   input  logic signed [OUT_W-1:0] out1_node2,
   input  logic signed [OUT_W-1:0] out1_node3,
   input  logic                    out10_ready_node0,
   input  logic                    out10_ready_node1,
   input  logic                    out10_ready_node2,
   input  logic                    out10_ready_node3,
   input  logic                    out11_ready_node0,
   input  logic                    out11_ready_node1,
   input  logic                    out11_ready_node2,
   input  logic                    out11_ready_node3,
   input  logic                    clr_err,
   output logic signed [OUT_W-1:0] res_data,
   output logic [2:0]              res_tag,
   output logic                    res_argmax,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic                    res_last,
   output logic                    err_partial,
   output logic                    err_overflow,
   output logic [7:0]              frame_cnt
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              idx_q, idx_d;
   logic signed [OUT_W-1:0] buf_q [8];
   logic signed [OUT_W-1:0] buf_d [8];
   logic [3:0]              am_q, am_d;
   logic [7:0]              frame_cnt_q, frame_cnt_d;
   logic                    err_partial_q, err_partial_d;
   logic                    err_overflow_q, err_overflow_d;

   logic [7:0]              rdy;
   logic                    cap_evt;
   logic                    part_evt;
   logic signed [OUT_W-1:0] scores [8];

   always_comb begin
      rdy = {out11_ready_node3, out10_ready_node3, out11_ready_node2, out10_ready_node2,
             out11_ready_node1, out10_ready_node1, out11_ready_node0, out10_ready_node0};
      cap_evt  = &rdy;
      part_evt = (|rdy) & ~(&rdy);

      // buffer index matches res_tag: {node, score}
      scores[0] = out0_node0;
      scores[1] = out1_node0;
      scores[2] = out0_node1;
      scores[3] = out1_node1;
      scores[4] = out0_node2;
      scores[5] = out1_node2;
      scores[6] = out0_node3;
      scores[7] = out1_node3;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      buf_d       = buf_q;
      am_d        = am_q;
      frame_cnt_d = frame_cnt_q;
      res_data    = '0;
      res_tag     = 3'd0;
      res_argmax  = 1'b0;
      res_valid   = 1'b0;
      res_last    = 1'b0;

      // a new event outranks a simultaneous clear
      err_partial_d  = part_evt | (err_partial_q & ~clr_err);
      err_overflow_d = (cap_evt & (state_q == SEND)) | (err_overflow_q & ~clr_err);

      case (state_q)
         IDLE: begin
            if (cap_evt) begin
               buf_d   = scores;
               am_d[0] = out1_node0 > out0_node0;
               am_d[1] = out1_node1 > out0_node1;
               am_d[2] = out1_node2 > out0_node2;
               am_d[3] = out1_node3 > out0_node3;
               idx_d   = 3'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            res_valid  = 1'b1;
            res_data   = buf_q[idx_q];
            res_tag    = idx_q;
            res_argmax = am_q[idx_q[2:1]];
            res_last   = (idx_q == 3'd7);
            if (res_ready) begin
               if (idx_q == 3'd7) begin
                  idx_d       = 3'd0;
                  state_d     = IDLE;
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         idx_q          <= 3'd0;
         am_q           <= 4'd0;
         frame_cnt_q    <= 8'd0;
         err_partial_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         am_q           <= am_d;
         frame_cnt_q    <= frame_cnt_d;
         err_partial_q  <= err_partial_d;
         err_overflow_q <= err_overflow_d;
         for (int i = 0; i < 8; i++) buf_q[i] <= buf_d[i];
      end
   end

   assign err_partial  = err_partial_q;
   assign err_overflow = err_overflow_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_gnn_result_unloader.sv
// tb/tb_gnn_result_unloader.sv - directed bench with a queue-based frame model for gnn_result_unloader
module tb_gnn_result_unloader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_err = 1'b0;
   logic res_ready = 1'b0;
   logic signed [20:0] o0 [4];
   logic signed [20:0] o1 [4];
   logic [3:0] r10 = 4'd0;
   logic [3:0] r11 = 4'd0;

   logic signed [20:0] res_data;
   logic [2:0]         res_tag;
   logic               res_argmax, res_valid, res_last;
   logic               err_partial, err_overflow;
   logic [7:0]         frame_cnt;

   int n_chk = 0;
   int n_fail = 0;

   gnn_result_unloader #(.OUT_W(21)) dut (
      .clk(clk), .rst_n(rst_n),
      .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
      .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
      .out10_ready_node0(r10[0]), .out10_ready_node1(r10[1]),
      .out10_ready_node2(r10[2]), .out10_ready_node3(r10[3]),
      .out11_ready_node0(r11[0]), .out11_ready_node1(r11[1]),
      .out11_ready_node2(r11[2]), .out11_ready_node3(r11[3]),
      .clr_err(clr_err),
      .res_data(res_data), .res_tag(res_tag), .res_argmax(res_argmax),
      .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
      .err_partial(err_partial), .err_overflow(err_overflow), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(expv));
      end
   endtask

   // model: a frame is a queue of expected words; nonempty queue means a word is on offer
   typedef struct packed {
      logic signed [20:0] d;
      logic [2:0]         t;
      logic               a;
   } word_t;

   word_t      m_q[$];
   logic [7:0] m_cnt = 8'd0;
   logic       m_part = 1'b0;
   logic       m_ovf = 1'b0;
   int         m_n;
   bit         m_busy;
   word_t      m_w;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_cnt  = 8'd0;
         m_part = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         m_n    = $countones({r11, r10});
         m_busy = (m_q.size() != 0);
         m_part = (m_n > 0 && m_n < 8) || (m_part && !clr_err);
         m_ovf  = (m_n == 8 && m_busy) || (m_ovf && !clr_err);
         if (m_busy && res_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_cnt = m_cnt + 8'd1;
         end
         if (m_n == 8 && !m_busy) begin
            for (int n = 0; n < 4; n++) begin
               m_w.a = (o1[n] > o0[n]);
               m_w.d = o0[n];
               m_w.t = 3'(2 * n);
               m_q.push_back(m_w);
               m_w.d = o1[n];
               m_w.t = 3'(2 * n + 1);
               m_q.push_back(m_w);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_q.size() != 0) begin
            chk("valid", res_valid, 1);
            chk("data", res_data, $signed(m_q[0].d));
            chk("tag", res_tag, m_q[0].t);
            chk("argmax", res_argmax, m_q[0].a);
            chk("last", res_last, m_q[0].t == 3'd7);
         end else begin
            chk("idle_valid", res_valid, 0);
            chk("idle_data", res_data, 0);
            chk("idle_tag", res_tag, 0);
            chk("idle_argmax", res_argmax, 0);
            chk("idle_last", res_last, 0);
         end
         chk("frame_cnt", frame_cnt, m_cnt);
         chk("err_partial", err_partial, m_part);
         chk("err_overflow", err_overflow, m_ovf);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic capture(input int s[8]);
      for (int n = 0; n < 4; n++) begin
         o0[n] = 21'(s[2 * n]);
         o1[n] = 21'(s[2 * n + 1]);
      end
      r10 = 4'hF;
      r11 = 4'hF;
      tick();
      r10 = 4'h0;
      r11 = 4'h0;
   endtask

   int basic[8] = '{5, -3, -2, 7, 4, 4, -1048576, 1048575};
   int exp_a[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   int other[8] = '{11, -12, 30, 30, -7, 0, 100, -100};
   int s[8];

   initial begin
      for (int n = 0; n < 4; n++) begin
         o0[n] = '0;
         o1[n] = '0;
      end
      tick();
      tick();
      @(negedge clk);
      chk("rst_valid", res_valid, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_errs", {err_partial, err_overflow}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // basic frame
      res_ready = 1'b1;
      capture(basic);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("basic_data", res_data, basic[i]);
         chk("basic_tag", res_tag, i);
         chk("basic_argmax", res_argmax, exp_a[i]);
         chk("basic_last", res_last, i == 7);
      end
      @(negedge clk);
      chk("basic_done_valid", res_valid, 0);
      chk("basic_frame_cnt", frame_cnt, 1);
      tick();

      // backpressure at idx 2
      capture(basic);
      tick();
      tick();
      res_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_hold_data", res_data, -2);
         chk("bp_hold_tag", res_tag, 2);
         tick();
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_hold_data", res_data, -2);
      repeat (6) tick();
      chk("bp_frame_cnt", frame_cnt, 2);

      // overflow at idx 4 and in the final-transfer cycle
      capture(basic);
      repeat (4) tick();
      for (int n = 0; n < 4; n++) begin
         o0[n] = 21'sd99;
         o1[n] = -21'sd99;
      end
      r10 = 4'hF;
      r11 = 4'hF;
      tick();
      r10 = 4'h0;
      r11 = 4'h0;
      @(negedge clk);
      chk("ovf_data_kept", res_data, 4);
      chk("ovf_flag", err_overflow, 1);
      tick();
      tick();
      r10 = 4'hF;
      r11 = 4'hF;
      tick();
      r10 = 4'h0;
      r11 = 4'h0;
      @(negedge clk);
      chk("ovf_done_valid", res_valid, 0);
      chk("ovf_frame_cnt", frame_cnt, 3);
      chk("ovf_flag2", err_overflow, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      @(negedge clk);
      chk("ovf_cleared", err_overflow, 0);
      tick();

      // partial events
      r10 = 4'b0100;
      tick();
      r10 = 4'b0000;
      @(negedge clk);
      chk("part_flag", err_partial, 1);
      chk("part_valid", res_valid, 0);
      tick();
      clr_err = 1'b1;
      r10 = 4'b0100;
      tick();
      clr_err = 1'b0;
      r10 = 4'b0000;
      @(negedge clk);
      chk("part_set_wins", err_partial, 1);
      tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      @(negedge clk);
      chk("part_cleared", err_partial, 0);
      tick();

      // reset mid-frame at idx 5
      capture(basic);
      repeat (5) tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_valid", res_valid, 0);
      chk("rstmid_frame_cnt", frame_cnt, 0);
      chk("rstmid_data", res_data, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("rstmid_idle", res_valid, 0);
      tick();
      capture(other);
      @(negedge clk);
      chk("rstmid_new_valid", res_valid, 1);
      chk("rstmid_new_data", res_data, 11);
      chk("rstmid_new_tag", res_tag, 0);
      repeat (8) tick();
      chk("rstmid_frame_cnt1", frame_cnt, 1);

      // wrap: 255 more frames make 256 since reset
      for (int f = 0; f < 255; f++) begin
         for (int k = 0; k < 8; k++) s[k] = ((f * 37 + k * 1013) % 2000) - 1000;
         capture(s);
         repeat (8) tick();
      end
      chk("wrap_zero", frame_cnt, 0);
      capture(basic);
      repeat (8) tick();
      chk("wrap_one", frame_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
